gamma_lut_ctrl: RTL and testbench
=================================

# gamma_lut_ctrl

Gamma-correction controller with a host-loadable, double-buffered lookup table. It replaces the fixed gamma ROM stage on the two-lane 8-bit pixel stream, between the raw-pixel source and the HDR merge path. The host writes a new curve into the shadow bank while the active bank keeps serving pixels. The banks swap only on a frame boundary, so no frame ever mixes two curves.

## Interface
- `DW`, 8 — pixel and LUT data width
- `AW`, 8 — LUT address width; table depth is 2^AW
- `clk` in 1 — system clock
- `reset_n` in 1 — asynchronous reset, active-low
- `raw_data_0`, `raw_data_1` in DW — lane 0 and lane 1 pixels
- `raw_data_valid`, `raw_data_sop`, `raw_data_eop` in 1 — beat qualifiers; sop and eop are meaningful only when valid is high
- `gamma_data_0`, `gamma_data_1` out DW — corrected pixels
- `gamma_data_valid`, `gamma_data_sop`, `gamma_data_eop` out 1 — qualifiers delayed to align with the data
- `cfg_wr_en` in 1 — write one shadow-bank entry
- `cfg_wr_addr` in AW — shadow-bank entry address
- `cfg_wr_data` in DW — shadow-bank entry data
- `cfg_commit` in 1 — request a bank swap at the next frame boundary
- `cfg_ready` out 1 — high when writes and commits are accepted
- `lut_loaded` out 1 — at least one swap has completed
- `active_bank` out 1 — index of the bank serving pixels
- `err_clr` in 1 — clears `frame_err`
- `frame_err` out 1 — sticky framing-violation flag

## Operation
- Two banks, 0 and 1. The active bank is read by both lanes; the shadow bank (`!active_bank`) is written by the host.
- `cfg_ready = !pending`.
- A write is taken only when `cfg_wr_en && cfg_ready`. Writes while `pending` is set are dropped.
- A commit is taken only when `cfg_commit && cfg_ready`; it sets `pending`. If a write and a commit arrive in the same cycle, the write lands first and is included in the swap.
- Frame FSM:
  - IDLE → FRAME on `valid && sop && !eop`.
  - FRAME → IDLE on `valid && eop`.
  - A beat with both sop and eop (single-beat frame) stays in IDLE.
- A swap flips `active_bank`, clears `pending` and sets `lut_loaded`. It fires at the clock edge ending a cycle where `pending` is set and either condition holds:
  - (a) FRAME with `valid && eop`; the eop beat reads the old bank.
  - (b) IDLE and not `(valid && sop)`.
- A pending swap never fires on an edge on which a frame starts.
- Bypass: while `lut_loaded == 0`, outputs are the inputs registered once, with no lookup.
- Framing errors set `frame_err`:
  - sop while in FRAME; this restarts the frame and the FSM stays in FRAME.
  - eop while in IDLE without sop; the beat is passed through.
- `err_clr` clears `frame_err`. If a set and a clear occur in the same cycle, the set wins.
- Beats with `valid == 0` are still looked up. Their data is don't-care, but their qualifiers propagate as zero.

## Timing
- Data latency is 1 cycle: the bank read is registered, and the qualifiers pass through a 1-stage register. `active_bank` and `lut_loaded` are also registered 1 stage to drive the output mux.
- Reset values:
  - all `gamma_*` outputs = 0
  - `active_bank` = 0, `lut_loaded` = 0, `frame_err` = 0
  - `pending` = 0, so `cfg_ready` = 1
  - FSM = IDLE
- Bank contents are not reset.
- A reset mid-frame or mid-load returns the block to bypass. Any partially loaded curve is discarded logically: the host must reload it and commit again.
- A write to the shadow bank is visible to pixels only after the commit and swap.
- The minimum commit-to-swap time is 1 edge when the block is in IDLE with no sop.

## Structure
- Package `gamma_pkg` holds:
  - `GAMMA_DW`, `GAMMA_AW` defaults
  - `frame_state_t` enum {IDLE, FRAME}
- One sub-module, `gamma_lut_bank`: 2^AW × DW RAM with one write port and two registered read ports. Instantiate it twice; the controller owns the write-enable steering and the output mux.

## Test plan
- After reset, stream pixels 0x10 and 0x80 → outputs 0x10 and 0x80 one cycle later; `lut_loaded` = 0.
- Load the inverse curve (data = 255 − addr), commit in IDLE → swap on the next edge, `active_bank` = 1; pixel 0x10 → 0xEF.
- Commit issued mid-frame → every pixel of the current frame uses the old curve; the swap occurs at the eop edge; the next frame's sop uses the new curve.
- Commit asserted in the same IDLE cycle as `valid && sop` → no swap in that frame; the swap happens at that frame's eop.
- While `pending`: write addr 0x10 = 0x00 → `cfg_ready` = 0 and the write is dropped; after the swap, pixel 0x10 still maps to 0xEF.
- sop twice without eop → `frame_err` = 1 and stays set until `err_clr`; a set and a clear in the same cycle leave it at 1.

Source files
------------

// File: rtl/gamma_pkg.sv
// Shared widths and frame-state encoding for the gamma LUT controller.
// Imported by the interface, the LUT bank and the controller top.
package gamma_pkg;

  localparam int GAMMA_DW = 8;
  localparam int GAMMA_AW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } frame_state_t;

endpackage

// File: rtl/gamma_lut_ctrl_if.sv
// Pixel stream, LUT config and status bundle for gamma_lut_ctrl.
// master: pixel source / host side; slave: the gamma controller.
interface gamma_lut_ctrl_if
  import gamma_pkg::*;
#(
  parameter int DW = GAMMA_DW,
  parameter int AW = GAMMA_AW
);

  logic [DW-1:0] raw_data_0;
  logic [DW-1:0] raw_data_1;
  logic          raw_data_valid;
  logic          raw_data_sop;
  logic          raw_data_eop;

  logic [DW-1:0] gamma_data_0;
  logic [DW-1:0] gamma_data_1;
  logic          gamma_data_valid;
  logic          gamma_data_sop;
  logic          gamma_data_eop;

  logic          cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [DW-1:0] cfg_wr_data;
  logic          cfg_commit;
  logic          cfg_ready;
  logic          lut_loaded;
  logic          active_bank;

  logic          err_clr;
  logic          frame_err;

  modport master (
    output raw_data_0, raw_data_1,
    output raw_data_valid, raw_data_sop,
    output raw_data_eop,
    input  gamma_data_0, gamma_data_1,
    input  gamma_data_valid, gamma_data_sop,
    input  gamma_data_eop,
    output cfg_wr_en, cfg_wr_addr,
    output cfg_wr_data, cfg_commit,
    input  cfg_ready, lut_loaded,
    input  active_bank,
    output err_clr,
    input  frame_err
  );

  modport slave (
    input  raw_data_0, raw_data_1,
    input  raw_data_valid, raw_data_sop,
    input  raw_data_eop,
    output gamma_data_0, gamma_data_1,
    output gamma_data_valid, gamma_data_sop,
    output gamma_data_eop,
    input  cfg_wr_en, cfg_wr_addr,
    input  cfg_wr_data, cfg_commit,
    output cfg_ready, lut_loaded,
    output active_bank,
    input  err_clr,
    output frame_err
  );

endinterface

// File: rtl/gamma_lut_bank.sv
// One gamma curve bank: 2^AW x DW RAM, one write port, two registered
// read ports (one per lane). Contents are deliberately not reset.
module gamma_lut_bank
  import gamma_pkg::*;
#(
  parameter int DW = GAMMA_DW,
  parameter int AW = GAMMA_AW
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr_0,
  input  logic [AW-1:0] rd_addr_1,
  output logic [DW-1:0] rd_data_0,
  output logic [DW-1:0] rd_data_1
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_0 <= mem[rd_addr_0];
    rd_data_1 <= mem[rd_addr_1];
  end

endmodule

// File: rtl/gamma_lut_ctrl.sv
// Double-buffered gamma LUT on a two-lane pixel stream; banks swap only
// on frame boundaries. Ports: clk, reset_n, bus (gamma_lut_ctrl_if.slave).
module gamma_lut_ctrl
  import gamma_pkg::*;
#(
  parameter int DW = GAMMA_DW,
  parameter int AW = GAMMA_AW
) (
  input  logic clk,
  input  logic reset_n,
  gamma_lut_ctrl_if.slave bus
);

  frame_state_t state;
  frame_state_t state_nxt;

  logic pending;
  logic act;
  logic loaded;
  logic err;

  logic beat_sop;
  logic beat_eop;
  logic wr_take;
  logic commit_take;
  logic swap;
  logic err_set;

  logic [DW-1:0] raw_q0;
  logic [DW-1:0] raw_q1;
  logic          vld_q;
  logic          sop_q;
  logic          eop_q;
  logic          act_q;
  logic          loaded_q;

  logic [DW-1:0] b0_d0;
  logic [DW-1:0] b0_d1;
  logic [DW-1:0] b1_d0;
  logic [DW-1:0] b1_d1;

  assign beat_sop = bus.raw_data_valid
                  & bus.raw_data_sop;
  assign beat_eop = bus.raw_data_valid
                  & bus.raw_data_eop;

  assign wr_take     = bus.cfg_wr_en & ~pending;
  assign commit_take = bus.cfg_commit & ~pending;

  // Frame-end swap reads the eop beat from the old bank because the
  // output mux uses act_q, captured on the same edge as the read.
  assign swap = pending
              & (((state == FRAME) & beat_eop)
              |  ((state == IDLE) & ~beat_sop));

  assign err_set = ((state == FRAME) & beat_sop)
                 | ((state == IDLE) & beat_eop & ~beat_sop);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (beat_sop && !beat_eop) state_nxt = FRAME;
      FRAME: if (beat_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      act     <= 1'b0;
      loaded  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (swap) begin
        pending <= 1'b0;
        act     <= ~act;
        loaded  <= 1'b1;
      end else if (commit_take) begin
        pending <= 1'b1;
      end
      if (err_set)          err <= 1'b1;
      else if (bus.err_clr) err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q0   <= '0;
      raw_q1   <= '0;
      vld_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      act_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      raw_q0   <= bus.raw_data_0;
      raw_q1   <= bus.raw_data_1;
      vld_q    <= bus.raw_data_valid;
      sop_q    <= beat_sop;
      eop_q    <= beat_eop;
      act_q    <= act;
      loaded_q <= loaded;
    end
  end

  // Host always writes the bank that is not serving pixels.
  gamma_lut_bank #(.DW(DW), .AW(AW)) u_bank0 (
    .clk       (clk),
    .wr_en     (wr_take & act),
    .wr_addr   (bus.cfg_wr_addr),
    .wr_data   (bus.cfg_wr_data),
    .rd_addr_0 (bus.raw_data_0[AW-1:0]),
    .rd_addr_1 (bus.raw_data_1[AW-1:0]),
    .rd_data_0 (b0_d0),
    .rd_data_1 (b0_d1)
  );

  gamma_lut_bank #(.DW(DW), .AW(AW)) u_bank1 (
    .clk       (clk),
    .wr_en     (wr_take & ~act),
    .wr_addr   (bus.cfg_wr_addr),
    .wr_data   (bus.cfg_wr_data),
    .rd_addr_0 (bus.raw_data_0[AW-1:0]),
    .rd_addr_1 (bus.raw_data_1[AW-1:0]),
    .rd_data_0 (b1_d0),
    .rd_data_1 (b1_d1)
  );

  assign bus.gamma_data_0 = !loaded_q ? raw_q0
                          : (act_q ? b1_d0 : b0_d0);
  assign bus.gamma_data_1 = !loaded_q ? raw_q1
                          : (act_q ? b1_d1 : b0_d1);

  assign bus.gamma_data_valid = vld_q;
  assign bus.gamma_data_sop   = sop_q;
  assign bus.gamma_data_eop   = eop_q;

  assign bus.cfg_ready   = ~pending;
  assign bus.lut_loaded  = loaded;
  assign bus.active_bank = act;
  assign bus.frame_err   = err;

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Directed bench for gamma_lut_ctrl: bypass, load/commit/swap timing,
// dropped writes while pending, framing errors and mid-frame reset.
module tb_gamma_lut_ctrl;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_err;

  gamma_lut_ctrl_if #(.DW(8), .AW(8)) bus ();

  gamma_lut_ctrl #(.DW(8), .AW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic s,
                      input logic e, input logic [7:0] d0,
                      input logic [7:0] d1);
    bus.raw_data_valid = v;
    bus.raw_data_sop   = s;
    bus.raw_data_eop   = e;
    bus.raw_data_0     = d0;
    bus.raw_data_1     = d1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0;
    beat(0, 0, 0, 8'h00, 8'h00);
    bus.cfg_wr_en   = 1'b0;
    bus.cfg_wr_addr = '0;
    bus.cfg_wr_data = '0;
    bus.cfg_commit  = 1'b0;
    bus.err_clr     = 1'b0;
    repeat (2) step();

    check("rst_d0", bus.gamma_data_0, 0);
    check("rst_vld", bus.gamma_data_valid, 0);
    check("rst_bank", bus.active_bank, 0);
    check("rst_loaded", bus.lut_loaded, 0);
    check("rst_err", bus.frame_err, 0);
    check("rst_ready", bus.cfg_ready, 1);
    reset_n = 1'b1;
    step();

    // bypass, single-beat frame
    beat(1, 1, 1, 8'h10, 8'h80);
    step();
    check("byp_d0", bus.gamma_data_0, 8'h10);
    check("byp_d1", bus.gamma_data_1, 8'h80);
    check("byp_sop", bus.gamma_data_sop, 1);
    check("byp_eop", bus.gamma_data_eop, 1);
    check("byp_loaded", bus.lut_loaded, 0);
    check("byp_err", bus.frame_err, 0);

    // invalid beat: qualifiers drop to zero
    beat(0, 1, 1, 8'h22, 8'h33);
    step();
    check("inv_vld", bus.gamma_data_valid, 0);
    check("inv_sop", bus.gamma_data_sop, 0);
    check("inv_eop", bus.gamma_data_eop, 0);

    // inverse curve into bank 1, last write with commit
    for (int a = 0; a < 256; a++) begin
      bus.cfg_wr_en   = 1'b1;
      bus.cfg_wr_addr = 8'(a);
      bus.cfg_wr_data = 8'(255 - a);
      bus.cfg_commit  = (a == 255);
      step();
    end
    bus.cfg_wr_en  = 1'b0;
    bus.cfg_commit = 1'b0;
    check("cmt_ready", bus.cfg_ready, 0);
    check("cmt_bank", bus.active_bank, 0);
    step();
    check("swp_bank", bus.active_bank, 1);
    check("swp_loaded", bus.lut_loaded, 1);
    check("swp_ready", bus.cfg_ready, 1);

    beat(1, 0, 0, 8'h10, 8'h80);
    step();
    check("inv_10", bus.gamma_data_0, 8'hEF);
    check("inv_80", bus.gamma_data_1, 8'h7F);
    beat(1, 0, 0, 8'hFF, 8'h00);
    step();
    check("inv_ff", bus.gamma_data_0, 8'h00);
    check("inv_00", bus.gamma_data_1, 8'hFF);
    beat(0, 0, 0, 8'h00, 8'h00);

    // curve xor 5A into bank 0
    for (int a = 0; a < 256; a++) begin
      bus.cfg_wr_en   = 1'b1;
      bus.cfg_wr_addr = 8'(a);
      bus.cfg_wr_data = 8'(a) ^ 8'h5A;
      step();
    end
    bus.cfg_wr_en = 1'b0;
    check("ld_bank", bus.active_bank, 1);

    // commit mid-frame
    beat(1, 1, 0, 8'h10, 8'h00);
    step();
    check("mf_sop", bus.gamma_data_0, 8'hEF);
    beat(1, 0, 0, 8'h20, 8'h00);
    bus.cfg_commit = 1'b1;
    step();
    bus.cfg_commit = 1'b0;
    check("mf_b1", bus.gamma_data_0, 8'hDF);
    beat(1, 0, 0, 8'h30, 8'h00);
    step();
    check("mf_b2", bus.gamma_data_0, 8'hCF);
    check("mf_hold", bus.active_bank, 1);
    beat(1, 0, 1, 8'h40, 8'h00);
    step();
    check("mf_eop", bus.gamma_data_0, 8'hBF);
    check("mf_swap", bus.active_bank, 0);
    beat(1, 1, 0, 8'h10, 8'h00);
    step();
    check("nf_sop", bus.gamma_data_0, 8'h4A);
    beat(1, 0, 1, 8'h11, 8'h00);
    step();
    check("nf_eop", bus.gamma_data_0, 8'h4B);

    // commit together with sop in IDLE
    beat(1, 1, 0, 8'h10, 8'h00);
    bus.cfg_commit = 1'b1;
    step();
    bus.cfg_commit = 1'b0;
    check("cs_d0", bus.gamma_data_0, 8'h4A);
    check("cs_bank", bus.active_bank, 0);
    check("cs_ready", bus.cfg_ready, 0);
    beat(1, 0, 0, 8'h20, 8'h00);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = 8'h10;
    bus.cfg_wr_data = 8'h00;
    step();
    bus.cfg_wr_en = 1'b0;
    check("cs_b1", bus.gamma_data_0, 8'h7A);
    check("cs_hold", bus.active_bank, 0);
    beat(1, 0, 1, 8'h30, 8'h00);
    step();
    check("cs_eop", bus.gamma_data_0, 8'h6A);
    check("cs_swap", bus.active_bank, 1);
    beat(1, 0, 0, 8'h10, 8'h00);
    step();
    check("drop_wr", bus.gamma_data_0, 8'hEF);

    // framing errors
    beat(1, 1, 0, 8'h10, 8'h00);
    step();
    check("fe_none", bus.frame_err, 0);
    step();
    check("fe_sop2", bus.frame_err, 1);
    beat(1, 0, 0, 8'h10, 8'h00);
    step();
    check("fe_stick", bus.frame_err, 1);
    beat(1, 1, 0, 8'h10, 8'h00);
    bus.err_clr = 1'b1;
    step();
    check("fe_setwin", bus.frame_err, 1);
    beat(1, 0, 1, 8'h10, 8'h00);
    step();
    bus.err_clr = 1'b0;
    check("fe_clr", bus.frame_err, 0);
    beat(1, 0, 1, 8'h20, 8'h00);
    step();
    check("fe_eop", bus.frame_err, 1);
    check("fe_eop_d", bus.gamma_data_0, 8'hDF);
    check("fe_eop_q", bus.gamma_data_eop, 1);
    beat(0, 0, 0, 8'h00, 8'h00);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("fe_clr2", bus.frame_err, 0);

    // reset mid-frame returns to bypass
    beat(1, 1, 0, 8'h10, 8'h00);
    step();
    reset_n = 1'b0;
    #1;
    check("mr_loaded", bus.lut_loaded, 0);
    check("mr_bank", bus.active_bank, 0);
    check("mr_vld", bus.gamma_data_valid, 0);
    check("mr_ready", bus.cfg_ready, 1);
    reset_n = 1'b1;
    beat(1, 0, 0, 8'h10, 8'h55);
    step();
    check("mr_byp0", bus.gamma_data_0, 8'h10);
    check("mr_byp1", bus.gamma_data_1, 8'h55);
    check("mr_err", bus.frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
